// File: rtl/deserializer.sv
// deserializer
//   Receive-side partner of the serializer. Collects an MSB-first bit stream
//   qualified by enable_i/start_i into DATA_WIDTH-bit words. Completed words
//   go into a small first-word-fall-through FIFO and are handed downstream on
//   a valid/ready handshake.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   serial_in_i     serial data bit, sampled only when enable_i=1
//   enable_i        bit-valid strobe
//   start_i         marks the MSB of a word (meaningful with enable_i=1)
//   parallel_out_o  head-of-FIFO word
//   valid_o         FIFO non-empty
//   ready_i         downstream accepts
//   framing_err_o   one-cycle pulse: a partial word was discarded by a restart
//   overflow_o      one-cycle pulse: a completed word was dropped (FIFO full)
//   level_o         current FIFO occupancy
//   dbg_state_o     receive FSM state (0 = IDLE, 1 = RECV)
//
// Handshake: a word transfers on every rising edge where valid_o && ready_i.
// valid_o never depends combinationally on ready_i, and parallel_out_o is
// held stable while valid_o=1 && ready_i=0. There is no back-pressure on the
// serial side; words lost to a full FIFO are reported only via overflow_o.

module deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               serial_in_i,
  input  logic                               enable_i,
  input  logic                               start_i,
  output logic [DATA_WIDTH-1:0]              parallel_out_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               framing_err_o,
  output logic                               overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o,
  output logic                               dbg_state_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  // Only DATA_WIDTH-1 bits are ever held: the last bit goes straight from
  // serial_in_i into the FIFO on the completing edge.
  logic [DATA_WIDTH-2:0]   r_shift;
  logic [CW-1:0]           r_count;

  logic                    w_load;
  logic                    w_shift_en;
  logic                    w_complete;
  logic                    w_framing;
  logic [DATA_WIDTH-1:0]   w_word;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [LW-1:0]           r_level;
  logic                    r_framing;
  logic                    r_overflow;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_overflow_evt;

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && start_i) w_next_state = ST_RECV;
      end
      ST_RECV: begin
        if (enable_i && !start_i && (r_count == CW'(DATA_WIDTH - 1))) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = 1'b0;
    w_shift_en = 1'b0;
    w_complete = 1'b0;
    w_framing  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Enabled bits without start while idle are stray and ignored.
        w_load = enable_i && start_i;
      end
      ST_RECV: begin
        if (enable_i) begin
          if (start_i) begin
            // Restart mid-word, including on what would have been the last bit.
            w_load    = 1'b1;
            w_framing = 1'b1;
          end else begin
            w_shift_en = 1'b1;
            w_complete = (r_count == CW'(DATA_WIDTH - 1));
          end
        end
      end
      default: ;
    endcase
  end

  assign dbg_state_o = r_state;

  // ---------------------------------------------------------------- shift path
  assign w_word = {r_shift, serial_in_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_shift <= (DATA_WIDTH-1)'(serial_in_i);
      r_count <= CW'(1);
    end else if (w_shift_en) begin
      r_shift <= (r_shift << 1) | (DATA_WIDTH-1)'(serial_in_i);
      r_count <= w_complete ? '0 : r_count + CW'(1);
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign w_full         = (r_level == LW'(FIFO_DEPTH));
  assign w_empty        = (r_level == '0);
  assign w_pop          = !w_empty && ready_i;
  // A pop in the same cycle frees the slot, so a word completing while full
  // is still accepted when the head leaves at the same edge.
  assign w_push         = w_complete && (!w_full || w_pop);
  assign w_overflow_evt = w_complete && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_framing  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
      r_framing  <= w_framing;
      r_overflow <= w_overflow_evt;
    end
  end

  // Fall-through read: the head slot is visible as soon as it is written.
  // When empty, the read pointer sits on a stale slot, which is acceptable
  // because the data is don't-care while valid_o=0.
  assign parallel_out_o = r_mem[r_rd_ptr];
  assign valid_o        = !w_empty;
  assign level_o        = r_level;
  assign framing_err_o  = r_framing;
  assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer (DATA_WIDTH=8, FIFO_DEPTH=2).
// Inputs change 2 time units after each rising edge. A reference model
// rebuilds words arithmetically from the sampled bits at each rising edge
// and pushes accepted words into exp_q. A monitor on the falling edge
// compares every DUT output against the model and pops exp_q on each
// handshake.

module tb_deserializer;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          serial;
  logic          en;
  logic          st;
  logic          ready;
  logic [DW-1:0] dout;
  logic          valid;
  logic          fe;
  logic          ov;
  logic [LW-1:0] level;
  logic          dbg_state;

  always #5 clk = ~clk;

  deserializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .serial_in_i    (serial),
    .enable_i       (en),
    .start_i        (st),
    .parallel_out_o (dout),
    .valid_o        (valid),
    .ready_i        (ready),
    .framing_err_o  (fe),
    .overflow_o     (ov),
    .level_o        (level),
    .dbg_state_o    (dbg_state)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_log[$];
  int            model_fifo[$];
  int            m_nbits = 0;
  int            m_word  = 0;
  bit            m_pop;
  bit            m_done;
  bit            exp_fe = 1'b0;
  bit            exp_ov = 1'b0;
  int            fe_cnt = 0;
  int            ov_cnt = 0;
  bit            rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  always @(posedge clk) begin
    if (rst) begin
      m_nbits = 0;
      m_word  = 0;
      model_fifo.delete();
      exp_q.delete();
      exp_fe = 1'b0;
      exp_ov = 1'b0;
    end else begin
      m_pop  = (model_fifo.size() > 0) && ready;
      m_done = 1'b0;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (en) begin
        if (st) begin
          if (m_nbits > 0) exp_fe = 1'b1;
          m_word  = int'(serial);
          m_nbits = 1;
        end else if (m_nbits > 0) begin
          m_word  = m_word * 2 + int'(serial);
          m_nbits = m_nbits + 1;
          if (m_nbits == DW) begin
            m_done  = 1'b1;
            m_nbits = 0;
          end
        end
      end
      if (m_pop) void'(model_fifo.pop_front());
      if (m_done) begin
        if (model_fifo.size() < DEPTH) begin
          model_fifo.push_back(m_word);
          exp_q.push_back(DW'(m_word));
        end else begin
          exp_ov = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    chk("valid", 32'(valid), 32'(model_fifo.size() != 0));
    chk("level", 32'(level), 32'(model_fifo.size()));
    chk("framing_err", 32'(fe), 32'(exp_fe));
    chk("overflow", 32'(ov), 32'(exp_ov));
    chk("never_both", 32'(fe & ov), 32'd0);
    chk("fsm_state", 32'(dbg_state), 32'(m_nbits != 0));
    if (fe) fe_cnt++;
    if (ov) ov_cnt++;
    if (valid && !rst) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", dout, $time);
      end else begin
        chk("data", 32'(dout), 32'(exp_q[0]));
        if (ready) begin
          out_log.push_back(dout);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #2;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    st = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input logic s, input int gap);
    en = 1'b0;
    st = 1'b0;
    repeat (gap) tick();
    en     = 1'b1;
    st     = s;
    serial = b;
    tick();
    en = 1'b0;
    st = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int maxgap);
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(w[i], i == DW - 1, int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic chk_log(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                         input logic [DW-1:0] e2, input int n);
    logic [DW-1:0] e [3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    chk({name, "_count"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n && i < out_log.size(); i++) begin
      chk({name, "_word"}, 32'(out_log[i]), 32'(e[i]));
    end
    out_log.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [DW-1:0] w44;
    int            r;

    rst    = 1'b1;
    serial = 1'b0;
    en     = 1'b0;
    st     = 1'b0;
    ready  = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(dout), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Contiguous word, immediate pop.
    ready = 1'b1;
    send_word(8'hA5, 0);
    chk("t1_latency_valid", 32'(valid), 32'd1);
    chk("t1_latency_data", 32'(dout), 32'hA5);
    idle(3);
    chk("t1_level", 32'(level), 32'd0);
    chk_log("t1", 8'hA5, 8'h00, 8'h00, 1);

    // Gaps between bits.
    fe_cnt = 0;
    ov_cnt = 0;
    send_word(8'h3C, 3);
    idle(3);
    chk_log("t2", 8'h3C, 8'h00, 8'h00, 1);
    chk("t2_errors", 32'(fe_cnt + ov_cnt), 32'd0);

    // Restart after 5 bits.
    for (int i = 0; i < 5; i++) send_bit(1'(i < 4), i == 0, 0);
    send_word(8'h81, 1);
    idle(3);
    chk("t3_framing_count", 32'(fe_cnt), 32'd1);
    chk_log("t3", 8'h81, 8'h00, 8'h00, 1);

    // Fill and overflow with ready low.
    ready  = 1'b0;
    ov_cnt = 0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_word(8'h33, 0);
    idle(2);
    chk("t4_level_full", 32'(level), 32'd2);
    chk("t4_overflow_count", 32'(ov_cnt), 32'd1);

    // Completion while full in the same cycle as a pop.
    w44 = 8'h44;
    for (int i = DW - 1; i >= 1; i--) send_bit(w44[i], i == DW - 1, 0);
    ready = 1'b1;
    send_bit(w44[0], 1'b0, 0);
    chk("t5_level", 32'(level), 32'd2);
    chk("t5_overflow_count", 32'(ov_cnt), 32'd1);
    idle(4);
    chk_log("t5", 8'h11, 8'h22, 8'h44, 3);

    // Reset with a full FIFO and a partial word.
    ready = 1'b0;
    send_word(8'h12, 0);
    send_word(8'h34, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, i == 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 0);
    chk("t6_stray_level", 32'(level), 32'd0);
    chk("t6_stray_state", 32'(dbg_state), 32'd0);
    ready = 1'b1;
    send_word(8'h5A, 1);
    idle(3);
    chk_log("t6", 8'h5A, 8'h00, 8'h00, 1);

    // Randomised traffic with random back-pressure.
    rand_ready = 1'b1;
    repeat (250) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        int k;
        k = int'($urandom_range(1, DW - 1));
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), i == 0, int'($urandom_range(0, 1)));
      end else if (r == 1) begin
        send_bit(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 2)));
      end
      send_word(DW'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
    end
    rand_ready = 1'b0;
    ready      = 1'b1;
    idle(DEPTH + 6);
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side partner of the team's serializer. Consumes an MSB-first bit stream qualified by enable/start strobes.
- Reassembles each DATA_WIDTH-bit word and buffers completed words in a small FIFO.
- Presents buffered words downstream on a valid/ready handshake.
- Flags framing errors (start mid-word) and overflow (word completes while FIFO full).

Parameters:
- DATA_WIDTH, 8, bits per word; must be >= 2.
- FIFO_DEPTH, 2, number of completed words buffered; must be >= 1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- serial_in_i  input  1  serial data bit; sampled only when enable_i=1.
- enable_i  input  1  bit-valid strobe.
- start_i  input  1  marks the first (MSB) bit of a word; only meaningful with enable_i=1.
- parallel_out_o  output  DATA_WIDTH  head-of-FIFO word.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  downstream accepts; pop when valid_o && ready_i.
- framing_err_o  output  1  one-cycle pulse: partial word discarded.
- overflow_o  output  1  one-cycle pulse: completed word dropped, FIFO full.
- level_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_i=1 at a clock edge) sets:
  - FSM to IDLE, shift register to 0, bit counter to 0, FIFO empty.
  - valid_o=0, parallel_out_o=0, level_o=0, framing_err_o=0, overflow_o=0.
  - A partial word is discarded silently.
- FSM states:
  - IDLE:
    - enable_i && start_i: load serial_in_i as the MSB, count=1, go to RECV.
    - enable_i && !start_i: stray bit; ignored, no error.
  - RECV:
    - enable_i && start_i: pulse framing_err_o; discard the partial word; restart with this bit as the new MSB, count=1; stay in RECV. This also applies when count=DATA_WIDTH-1.
    - enable_i && !start_i: shift left, insert serial_in_i at the LSB, count+1.
    - When the accepted bit makes count=DATA_WIDTH: the word is complete; push it to the FIFO; return to IDLE with count=0.
    - enable_i=0: hold all state. Gaps of any length are allowed mid-word; there is no timeout.
- Word ordering: the first received bit lands in bit DATA_WIDTH-1, the last in bit 0.
- Latency: the word appears at parallel_out_o with valid_o=1 on the cycle after the edge that sampled its last bit, provided the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through; parallel_out_o is held stable while valid_o=1 && ready_i=0.
  - parallel_out_o is don't-care when valid_o=0; it keeps its last value.
  - Push and pop in the same cycle: level unchanged, ordering preserved.
  - Completion while full and no pop that cycle: drop the new word, pulse overflow_o, FIFO contents untouched.
  - Completion while full with a pop that cycle: push accepted, no overflow.
  - Pop when empty: no effect.
  - Read and write pointers wrap modulo FIFO_DEPTH; the level counter never exceeds FIFO_DEPTH.
- Error pulses:
  - framing_err_o and overflow_o are registered and last exactly one cycle per event.
  - Both may assert in the same cycle only if the events coincide; by construction they cannot, so the bench asserts never-both.
- No back-pressure to the serial side: the bit stream is never stalled; lost words are reported only via overflow_o.

Test Plan:
- DATA_WIDTH=8. Send 0xA5 as start+8 contiguous enabled bits, ready_i=1 -> valid_o=1 with parallel_out_o=0xA5 one cycle after the last bit; level_o returns to 0 after the pop.
- Send 0x3C with enable_i gaps of 0–3 cycles between bits -> 0x3C output once, no error pulses.
- Send 5 bits of a word, then start a new word 0x81 -> framing_err_o pulses once at the restart; only 0x81 is output.
- ready_i=0, FIFO_DEPTH=2: send 0x11, 0x22, 0x33 -> level_o=2 and overflow_o pulses on completion of 0x33; after ready_i=1 the outputs are 0x11 then 0x22.
- FIFO full, 0x44 completes in the same cycle ready_i=1 pops the head -> no overflow, level_o stays 2, the output order continues with 0x44 last.
- Assert rst_i mid-word and with a full FIFO -> next cycle valid_o=0, level_o=0; a following clean word 0x5A is received correctly; enabled bits without start while IDLE are ignored.
